pwm_duty_meter: RTL and testbench
=================================

// Module: pwm_duty_meter
// PURPOSE
//  Measures an incoming active-low PWM LED drive: on-time (low cycles) and period per PWM cycle.
//  Sits beside the breathing-LED PWM stage as its readback/decoder for self-test.
//  Publishes a duty/period pair with a one-cycle valid strobe per complete period.
//  Reports an overflow when no period completes within CNT_MAX cycles.
// PARAMETERS
//  CNT_MAX      255  longest measurable period in clk cycles.
//                    Counter width W = util.get_width(CNT_MAX), so CNT_MAX is representable.
//  SYNC_STAGES  2    input synchronizer depth, >=2.
// PORTS
//  clk     in   1  system clock, rising edge.
//  rst     in   1  asynchronous, active-high reset.
//  pwm_in  in   1  async PWM level; 0 = LED on.
//  duty    out  W  low-cycle count of the last reported period.
//  period  out  W  clk-cycle length of the last reported period.
//  valid   out  1  one-cycle strobe: duty/period just updated.
//  ovf     out  1  one-cycle strobe: CNT_MAX cycles without a falling edge.
// BEHAVIOUR
//  - Reset (async, rst=1):
//      sync chain and edge flop <= 1; state <= IDLE; per_cnt = on_cnt = 0;
//      duty = period = 0; valid = ovf = 0.
//  - Synchronizer and edge detect:
//      pwm_in passes through SYNC_STAGES flops -> s; s_d is s delayed 1 cycle.
//      fall = s_d & ~s.
//      Pin edge to fall: SYNC_STAGES+1 cycles.
//  - FSM states: IDLE (no period reference yet), MEASURE.
//  - IDLE, every cycle:
//      per_cnt += 1; on_cnt += ~s.
//      On fall: per_cnt <= 1, on_cnt <= 1, go to MEASURE, no valid.
//  - MEASURE, every cycle without fall: per_cnt += 1; on_cnt += ~s.
//  - MEASURE on fall:
//      duty <= on_cnt; period <= per_cnt; valid = 1 next cycle.
//      per_cnt <= 1; on_cnt <= 1, because the fall cycle is the first low cycle of the new period.
//  - Period sync: a period runs falling edge to falling edge, so the first valid needs two falls after reset.
//  - Overflow: when per_cnt == CNT_MAX and no fall this cycle, in either state:
//      ovf = 1 next cycle; per_cnt <= 0; on_cnt <= 0; state <= IDLE.
//      ovf then repeats every CNT_MAX+1 cycles while the input stays stuck.
//  - Fall in the same cycle per_cnt == CNT_MAX: the fall wins and the period reports as normal.
//      No ovf is raised.
//  - Counters never exceed CNT_MAX, so no wrap can occur.
//  - duty <= period always holds.
//  - Outputs: duty, period, valid and ovf are all registered.
//      duty and period hold between updates.
//  - Simultaneous events: fall and overflow are mutually exclusive, with fall taking priority.
//      valid and ovf are never both 1 unless PWM_METER_STUCK_EN is defined.
//  - Reset mid-period: the partial measurement is discarded and outputs clear immediately.
// CONFIGURATION
//  PWM_METER_STUCK_EN defined:
//      on overflow also set duty <= on_cnt, period <= CNT_MAX, valid = 1 in the same cycle as ovf.
//      Constant high reports duty = 0; constant low reports duty = CNT_MAX.
//      Reports 0 % and 100 % brightness.
//  Not defined:
//      overflow raises ovf only; valid stays 0; duty and period hold their previous values.
// TESTING
//  1. Assert rst, release, hold pwm_in=1 for 20 cycles
//     -> duty = period = 0, valid = ovf = 0 throughout.
//  2. Drive period 8 with 3 cycles low (repeating)
//     -> first valid after the 2nd fall, duty=3 period=8.
//     -> valid then strobes every 8 cycles with the same values.
//  3. Switch the low time from 3 to 5 mid-stream
//     -> the period containing the change reports 5/8 or 3/8, never any other value.
//     -> every subsequent period reports 5/8.
//  4. After test 2, hold pwm_in=1, CNT_MAX=255
//     -> ovf pulses 255 cycles after the last counted edge and then every 256 cycles.
//     -> With PWM_METER_STUCK_EN: valid with duty=0, period=255.
//     -> Without it: valid=0 and outputs stay 3/8.
//  5. Hold pwm_in=0 continuously
//     -> with the macro, duty=255, period=255 on each ovf.
//     -> without it, ovf only.
//  6. Assert rst 4 cycles into a 5/8 period
//     -> outputs clear immediately.
//     -> after release, no valid until two falls, then duty=5 period=8.

Source files
------------

// File: rtl/pwm_duty_meter.sv
// Active-low PWM readback: measures low-cycle count and period per PWM cycle.
// Define PWM_METER_STUCK_EN to also report 0 %/100 % duty on overflow.
module pwm_duty_meter #(
    parameter int CNT_MAX     = 255,
    parameter int SYNC_STAGES = 2,
    localparam int W          = $clog2(CNT_MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pwm_in,
    output logic [W-1:0] duty,
    output logic [W-1:0] period,
    output logic         valid,
    output logic         ovf
);

    localparam logic [W-1:0] MAX = W'(CNT_MAX);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q;
    logic                   s;
    logic                   fall;

    logic [W-1:0] per_cnt_q, per_cnt_d;
    logic [W-1:0] on_cnt_q, on_cnt_d;
    logic [W-1:0] duty_q, duty_d;
    logic [W-1:0] period_q, period_d;
    logic         valid_q, valid_d;
    logic         ovf_q, ovf_d;

    assign s      = sync_q[SYNC_STAGES-1];
    assign fall   = s_d_q & ~s;
    assign sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};

    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q + 1'b1;
        on_cnt_d  = on_cnt_q + {{(W-1){1'b0}}, ~s};
        duty_d    = duty_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        ovf_d     = 1'b0;

        if (fall) begin
            // The fall cycle is the first low cycle of the new period.
            per_cnt_d = {{(W-1){1'b0}}, 1'b1};
            on_cnt_d  = {{(W-1){1'b0}}, 1'b1};
            state_d   = MEASURE;
            if (state_q == MEASURE) begin
                duty_d   = on_cnt_q;
                period_d = per_cnt_q;
                valid_d  = 1'b1;
            end
        end else if (per_cnt_q == MAX) begin
            per_cnt_d = '0;
            on_cnt_d  = '0;
            state_d   = IDLE;
            ovf_d     = 1'b1;
`ifdef PWM_METER_STUCK_EN
            duty_d    = on_cnt_q;
            period_d  = MAX;
            valid_d   = 1'b1;
`else
            valid_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '1;
            s_d_q     <= 1'b1;
            state_q   <= IDLE;
            per_cnt_q <= '0;
            on_cnt_q  <= '0;
            duty_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            s_d_q     <= s;
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            on_cnt_q  <= on_cnt_d;
            duty_q    <= duty_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign duty   = duty_q;
    assign period = period_q;
    assign valid  = valid_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter: reset, steady PWM, duty change,
// stuck-high/low overflow and mid-period reset.
module tb_pwm_duty_meter;

    logic       clk;
    logic       rst;
    logic       pwm_in;
    logic [7:0] duty;
    logic [7:0] period;
    logic       valid;
    logic       ovf;

    int n_chk  = 0;
    int n_fail = 0;

    int ncyc        = 0;
    int vcnt        = 0;
    int first_v_cyc = 0;
    int last_v_cyc  = 0;
    int vbad        = 0;
    int vint_bad    = 0;
    int ocnt        = 0;
    int first_o_cyc = 0;
    int last_o_cyc  = 0;
    int oint_bad    = 0;
    int both_cnt    = 0;
    int ea_d = 0, ea_p = 0, eb_d = 0, eb_p = 0;
    int n0, lv;

    pwm_duty_meter #(
        .CNT_MAX    (255),
        .SYNC_STAGES(2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .pwm_in(pwm_in),
        .duty  (duty),
        .period(period),
        .valid (valid),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pwm_periods(input int lo, input int per, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < per; i++) begin
                pwm_in = (i >= lo);
                step(1);
            end
        end
    endtask

    task automatic clr_stats();
        vcnt     = 0;
        vbad     = 0;
        vint_bad = 0;
        ocnt     = 0;
        oint_bad = 0;
        both_cnt = 0;
    endtask

    task automatic set_exp(input int ad, input int ap,
                           input int bd, input int bp);
        ea_d = ad;
        ea_p = ap;
        eb_d = bd;
        eb_p = bp;
    endtask

    // Output monitor, sampling on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            if (valid) begin
                if (vcnt > 0 && ncyc - last_v_cyc != 8) vint_bad++;
                if (vcnt == 0) first_v_cyc = ncyc;
                if (!((duty == ea_d && period == ea_p) ||
                      (duty == eb_d && period == eb_p))) vbad++;
                vcnt++;
                last_v_cyc = ncyc;
            end
            if (ovf) begin
                if (ocnt > 0 && ncyc - last_o_cyc != 256) oint_bad++;
                if (ocnt == 0) first_o_cyc = ncyc;
                ocnt++;
                last_o_cyc = ncyc;
            end
            if (valid && ovf) both_cnt++;
        end
    end

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b1;
        step(3);
        chk("rst_duty", int'(duty), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_ovf", int'(ovf), 0);
        rst = 1'b0;

        // Idle high after reset.
        clr_stats();
        step(20);
        chk("idle_duty", int'(duty), 0);
        chk("idle_period", int'(period), 0);
        chk("idle_vcnt", vcnt, 0);
        chk("idle_ocnt", ocnt, 0);

        // Steady 3/8.
        clr_stats();
        set_exp(3, 8, 3, 8);
        n0 = ncyc;
        pwm_periods(3, 8, 6);
        pwm_in = 1'b1;
        chk("p38_vcnt", vcnt, 5);
        chk("p38_first", first_v_cyc - n0, 12);
        chk("p38_vals", vbad, 0);
        chk("p38_intv", vint_bad, 0);
        chk("p38_duty", int'(duty), 3);
        chk("p38_period", int'(period), 8);

        // Stuck high after 3/8.
        lv = last_v_cyc;
        clr_stats();
        step(600);
        chk("hi_ocnt", ocnt, 2);
        chk("hi_first_ovf", first_o_cyc - lv, 255);
        chk("hi_ovf_intv", oint_bad, 0);
`ifdef PWM_METER_STUCK_EN
        chk("hi_vcnt", vcnt, 2);
        chk("hi_duty", int'(duty), 0);
        chk("hi_period", int'(period), 255);
`else
        chk("hi_vcnt", vcnt, 0);
        chk("hi_duty", int'(duty), 3);
        chk("hi_period", int'(period), 8);
        chk("hi_both", both_cnt, 0);
`endif

        // Low time switches 3 -> 5 mid-stream.
        clr_stats();
        set_exp(3, 8, 5, 8);
        pwm_periods(3, 8, 3);
        pwm_periods(5, 8, 4);
        chk("chg_vcnt", vcnt, 6);
        chk("chg_vals", vbad, 0);
        chk("chg_intv", vint_bad, 0);
        chk("chg_duty", int'(duty), 5);
        chk("chg_period", int'(period), 8);

        // Stuck low.
        pwm_in = 1'b0;
        step(10);
        chk("lo_pre_duty", int'(duty), 5);
        clr_stats();
        step(560);
        chk("lo_ocnt", ocnt, 2);
        chk("lo_ovf_intv", oint_bad, 0);
`ifdef PWM_METER_STUCK_EN
        chk("lo_vcnt", vcnt, 2);
        chk("lo_duty", int'(duty), 255);
        chk("lo_period", int'(period), 255);
`else
        chk("lo_vcnt", vcnt, 0);
        chk("lo_duty", int'(duty), 5);
        chk("lo_period", int'(period), 8);
`endif

        // Reset four cycles into a 5/8 period.
        pwm_in = 1'b1;
        step(4);
        clr_stats();
        set_exp(5, 8, 5, 8);
        pwm_periods(5, 8, 2);
        chk("mr_pre_vcnt", vcnt, 1);
        chk("mr_pre_duty", int'(duty), 5);
        pwm_in = 1'b0;
        step(4);
        rst = 1'b1;
        #1;
        chk("mr_duty", int'(duty), 0);
        chk("mr_period", int'(period), 0);
        chk("mr_valid", int'(valid), 0);
        chk("mr_ovf", int'(ovf), 0);
        pwm_in = 1'b1;
        step(2);
        rst = 1'b0;
        clr_stats();
        n0 = ncyc;
        pwm_periods(5, 8, 4);
        pwm_in = 1'b1;
        chk("mr_vcnt", vcnt, 3);
        chk("mr_first", first_v_cyc - n0, 12);
        chk("mr_vals", vbad, 0);
        chk("mr_duty2", int'(duty), 5);
        chk("mr_period2", int'(period), 8);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
